// File: rtl/dmem_bridge.sv
// dmem_bridge: memory-stage to shared data memory bridge with valid/ready request and response handshake.
// Optional WAIT timeout with error response when DMEM_BRIDGE_TIMEOUT_EN is defined.
module dmem_bridge #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                arst_n,
   input  logic                core_req_valid,
   input  logic                core_req_we,
   input  logic [DATA_W/8-1:0] core_req_mask,
   input  logic [ADDR_W-1:0]   core_req_addr,
   input  logic [DATA_W-1:0]   core_req_wdata,
   output logic                core_stall,
   output logic                core_rsp_valid,
   output logic [DATA_W-1:0]   core_rsp_rdata,
   output logic                core_rsp_err,
   output logic                bus_req_valid,
   input  logic                bus_req_ready,
   output logic                bus_we,
   output logic [DATA_W/8-1:0] bus_mask,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic                bus_rsp_valid,
   input  logic [DATA_W-1:0]   bus_rsp_rdata
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   state_t state, state_nxt;
   logic latch_req;
   logic rsp_load;
   logic rsp_err_nxt;
   logic [DATA_W-1:0] rsp_rdata_nxt;
   logic timeout;
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("dmem_bridge: TIMEOUT_CYCLES must be 1..65535");
   end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
   logic [15:0] wait_cnt;
   // Holding the count at zero through REQ leaves it cleared on WAIT entry.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) wait_cnt <= '0;
      else if (state == REQ) wait_cnt <= '0;
      else if (state == WAIT && !bus_rsp_valid) wait_cnt <= wait_cnt + 16'd1;
   end
   assign timeout = (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      latch_req = 1'b0;
      rsp_load = 1'b0;
      rsp_err_nxt = 1'b0;
      rsp_rdata_nxt = '0;
      case (state)
         IDLE: if (core_req_valid) begin
            latch_req = |core_req_mask;
            rsp_load = ~|core_req_mask;
            state_nxt = |core_req_mask ? REQ : DONE;
         end
         REQ: if (bus_req_ready) state_nxt = WAIT;
         // A response in the expiry cycle wins over the timeout.
         WAIT: if (bus_rsp_valid || timeout) begin
            rsp_load = 1'b1;
            rsp_err_nxt = ~bus_rsp_valid;
            rsp_rdata_nxt = (bus_rsp_valid && !bus_we) ? bus_rsp_rdata : '0;
            state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         bus_we <= 1'b0;
         bus_mask <= '0;
         bus_addr <= '0;
         bus_wdata <= '0;
      end else if (latch_req) begin
         bus_we <= core_req_we;
         bus_mask <= core_req_mask;
         bus_addr <= core_req_addr;
         bus_wdata <= core_req_wdata;
      end
   end
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         core_rsp_rdata <= '0;
         core_rsp_err <= 1'b0;
      end else if (rsp_load) begin
         core_rsp_rdata <= rsp_rdata_nxt;
         core_rsp_err <= rsp_err_nxt;
      end
   end
   assign core_stall = (state == IDLE && core_req_valid) || state == REQ || state == WAIT;
   assign core_rsp_valid = (state == DONE);
   assign bus_req_valid = (state == REQ);
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: randomized and directed checks of dmem_bridge against a latency/data model of the access protocol.
module tb_dmem_bridge;
   localparam int T = 4;
   logic clk = 0;
   logic arst_n;
   logic core_req_valid, core_req_we;
   logic [3:0] core_req_mask;
   logic [31:0] core_req_addr, core_req_wdata;
   logic core_stall, core_rsp_valid, core_rsp_err;
   logic [31:0] core_rsp_rdata;
   logic bus_req_valid, bus_req_ready, bus_we, bus_rsp_valid;
   logic [3:0] bus_mask;
   logic [31:0] bus_addr, bus_wdata, bus_rsp_rdata;
   int passed = 0, total = 0, cyc = 0, pulse_cyc = 0;

   dmem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .arst_n(arst_n),
      .core_req_valid(core_req_valid), .core_req_we(core_req_we), .core_req_mask(core_req_mask),
      .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
      .core_stall(core_stall), .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata),
      .core_rsp_err(core_rsp_err), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
      .bus_we(bus_we), .bus_mask(bus_mask), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Quiet cycles with bus noise: nothing may stall, pulse or request.
   task automatic idle(input int n, input bit force_rsp, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         core_req_valid = 0;
         bus_req_ready = 1'($urandom_range(0, 1));
         bus_rsp_valid = force_rsp ? 1'b1 : 1'($urandom_range(0, 1));
         bus_rsp_rdata = $urandom;
         #1;
         check({tag, "_rsp_valid"}, 32'(core_rsp_valid), 0);
         check({tag, "_stall"}, 32'(core_stall), 0);
         check({tag, "_bus_req"}, 32'(bus_req_valid), 0);
      end
   endtask

   // One access; the bus waits rdy_d cycles before ready and answers after rsp_d silent WAIT cycles.
   task automatic access(input logic we, input logic [3:0] mask, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int rdy_d, input int rsp_d, input string tag);
      int stalls, reqs, waits, wait_cyc, exp_stalls;
      bit in_wait, done, seen_req, bad_fields, err_e;
      logic [31:0] exp_rd;
      wait_cyc = rsp_d + 1;
      err_e = 0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      if (rsp_d >= T) begin
         wait_cyc = T;
         err_e = 1;
      end
`endif
      exp_stalls = (mask == 0) ? 1 : 2 + rdy_d + wait_cyc;
      exp_rd = (mask == 0 || we || err_e) ? 32'h0 : rdata;
      stalls = 0; reqs = 0; waits = 0;
      in_wait = 0; done = 0; seen_req = 0; bad_fields = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         core_req_valid = 1;
         core_req_we = we;
         core_req_mask = mask;
         core_req_addr = addr;
         core_req_wdata = wdata;
         bus_req_ready = (reqs >= rdy_d);
         bus_rsp_valid = in_wait ? (waits >= rsp_d) : 1'($urandom_range(0, 1));
         bus_rsp_rdata = in_wait ? rdata : $urandom;
         #1;
         if (core_stall) stalls++;
         seen_req |= bus_req_valid;
         if (bus_req_valid || in_wait)
            bad_fields |= ({bus_we, bus_mask, bus_addr, bus_wdata} !== {we, mask, addr, wdata});
         if (core_rsp_valid) begin
            done = 1;
            pulse_cyc = cyc;
            check({tag, "_done_stall"}, 32'(core_stall), 0);
            check({tag, "_rdata"}, core_rsp_rdata, exp_rd);
            check({tag, "_err"}, 32'(core_rsp_err), 32'(err_e));
         end
         if (in_wait) begin
            if (bus_rsp_valid) in_wait = 0;
            waits++;
         end else if (bus_req_valid) begin
            reqs++;
            if (bus_req_ready) in_wait = 1;
         end
      end
      check({tag, "_completed"}, 32'(done), 1);
      check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
      check({tag, "_bus_req_seen"}, 32'(seen_req), 32'(mask != 0));
      check({tag, "_bus_fields"}, 32'(bad_fields), 0);
   endtask

   initial begin
      int p0;
      arst_n = 0;
      core_req_valid = 0; core_req_we = 0; core_req_mask = 0; core_req_addr = 0; core_req_wdata = 0;
      bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_rdata = 0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_stall", 32'(core_stall), 0);
      check("rst_rsp_valid", 32'(core_rsp_valid), 0);
      check("rst_rdata", core_rsp_rdata, 0);
      check("rst_err", 32'(core_rsp_err), 0);
      check("rst_bus_req", 32'(bus_req_valid), 0);
      check("rst_bus_addr", bus_addr, 0);
      @(negedge clk);
      arst_n = 1;
      idle(2, 0, "idle0");
      access(0, 4'hF, 32'h100, 32'h0, 32'hCAFEBABE, 0, 0, "load");
      idle(1, 0, "hold");
      check("hold_rdata", core_rsp_rdata, 32'hCAFEBABE);
      access(1, 4'b0011, 32'h204, 32'h1234, 32'hDEADBEEF, 2, 0, "store");
      idle(1, 0, "idle1");
      access(0, 4'h0, 32'h300, 32'h0, 32'h5555AAAA, 0, 0, "zmask");
      idle(1, 0, "idle2");
      access(0, 4'hF, 32'h10, 32'h0, 32'h11, 0, 0, "b2b0");
      p0 = pulse_cyc;
      access(0, 4'hF, 32'h14, 32'h0, 32'h22, 0, 0, "b2b1");
      check("b2b_spacing", 32'(pulse_cyc - p0), 4);
      idle(1, 0, "idle3");
      @(negedge clk);
      core_req_valid = 1; core_req_we = 0; core_req_mask = 4'hF; core_req_addr = 32'h400;
      bus_req_ready = 1; bus_rsp_valid = 0;
      repeat (2) @(negedge clk);
      #1;
      check("rstw_stall_in_wait", 32'(core_stall), 1);
      core_req_valid = 0;
      arst_n = 0;
      #1;
      check("rstw_stall", 32'(core_stall), 0);
      check("rstw_bus_req", 32'(bus_req_valid), 0);
      check("rstw_bus_addr", bus_addr, 0);
      check("rstw_bus_mask", 32'(bus_mask), 0);
      check("rstw_rdata", core_rsp_rdata, 0);
      @(negedge clk);
      arst_n = 1;
      idle(1, 0, "rstw_rel");
      idle(2, 1, "rstw_late");
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      access(0, 4'hF, 32'h500, 32'h0, 32'h77, 1, 1000, "tmo");
      idle(2, 1, "tmo_late");
      access(0, 4'hF, 32'h504, 32'h0, 32'h88, 0, T - 1, "tmo_edge");
      idle(1, 0, "idle4");
`endif
      for (int i = 0; i < 40; i++) begin
         logic [3:0] m;
         m = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
`ifdef DMEM_BRIDGE_TIMEOUT_EN
         access(1'($urandom_range(0, 1)), m, $urandom, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 6), $sformatf("rnd%0d", i));
`else
         access(1'($urandom_range(0, 1)), m, $urandom, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", i));
`endif
         if ($urandom_range(0, 1) == 1) idle(1, 0, $sformatf("rnd_idle%0d", i));
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Sequential bridge between the memory stage and the shared data memory. It captures the stage's shared-memory request (address, write data, byte mask, direction) and runs a valid/ready request plus response handshake on the memory bus. It stalls the pipeline until the access completes, then returns read data to the memory stage's `lsu_rdata` path for one cycle.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; the mask is `DATA_W/8` bits wide.
- `TIMEOUT_CYCLES`, 255: maximum WAIT cycles before an error response. Only used with `DMEM_BRIDGE_TIMEOUT_EN`. Legal range is 1..65535.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `arst_n`  in  1  asynchronous, active-low reset.
- `core_req_valid`  in  1  memory stage has a data-memory access (`dm_en` for loads or stores).
- `core_req_we`  in  1  1 = store, 0 = load.
- `core_req_mask`  in  4  byte enables (`mask`).
- `core_req_addr`  in  32  byte address (`core_out_mem_addr_in`).
- `core_req_wdata`  in  32  store data (`core_out_mem_data_in`).
- `core_stall`  out  1  freezes the pipeline registers upstream of and including the memory stage.
- `core_rsp_valid`  out  1  one-cycle completion pulse.
- `core_rsp_rdata`  out  32  load data; 0 for stores.
- `core_rsp_err`  out  1  the access timed out.
- `bus_req_valid`  out  1  bus request valid.
- `bus_req_ready`  in  1  bus accepts the request.
- `bus_we`, `bus_mask`, `bus_addr`, `bus_wdata`  out  1/4/32/32  registered request fields.
- `bus_rsp_valid`  in  1  bus response; the bus gives one response per accepted request, for both loads and stores.
- `bus_rsp_rdata`  in  32  bus read data.

## Operation
The block is a state machine with four states: IDLE, REQ, WAIT, DONE.

- **IDLE**
  - On `core_req_valid` with a non-zero mask: latch `we/mask/addr/wdata` into the bus registers and go to REQ.
  - On `core_req_valid` with `mask == 0`: issue no bus transaction, force rdata to 0, and go to DONE.
  - `bus_rsp_valid` is ignored in IDLE.
- **REQ**
  - `bus_req_valid = 1`.
  - On `bus_req_ready`: go to WAIT.
  - `bus_rsp_valid` is ignored in REQ; a response is only legal after the handshake.
- **WAIT**
  - On `bus_rsp_valid`: latch `bus_rsp_rdata`, or 0 when `we` = 1, and go to DONE.
- **DONE**
  - `core_rsp_valid = 1`, `core_stall = 0`, then go to IDLE unconditionally.
- **Stall rule:** `core_stall = (state==IDLE & core_req_valid) | state==REQ | state==WAIT`. The IDLE term is combinational. The core holds its request stable while stalled.
- **Bus registers:** `bus_*` fields are stable from REQ entry through WAIT exit.
- **Response data:** `core_rsp_rdata` and `core_rsp_err` hold their last values outside DONE; consumers qualify them with `core_rsp_valid`.
- **Reset:** asserting `arst_n` mid-transaction returns the block to IDLE immediately. Any outstanding bus response is then dropped in IDLE.

## Timing
- Reset values: state IDLE; all outputs 0 (`core_stall` 0 when `core_req_valid` = 0).
- Minimum latency, bus ready and response with no wait states:
  - cycle 0: request seen in IDLE, stall = 1.
  - cycle 1: REQ with ready = 1.
  - cycle 2: WAIT with response.
  - cycle 3: DONE with `core_rsp_valid`.
  - Result: 3 stall cycles.
- Each cycle with `bus_req_ready = 0` adds one cycle. Each cycle without a response adds one cycle.
- Zero-mask access: stall in cycle 0, DONE in cycle 1.
- Back-to-back accesses: the next request is sampled in IDLE on the cycle after DONE, so at most one access completes every 4 cycles.

## Configuration
- **`DMEM_BRIDGE_TIMEOUT_EN` defined:**
  - A 16-bit counter clears on WAIT entry and increments in each WAIT cycle without a response.
  - When the count reaches `TIMEOUT_CYCLES`, the block goes to DONE with `core_rsp_err = 1` and `core_rsp_rdata = 0`.
  - A response arriving in the same cycle as expiry wins, with err = 0.
  - A late response arriving after the timeout falls into IDLE and is ignored.
- **Undefined:** there is no counter, `core_rsp_err` is tied to 0, and WAIT waits indefinitely.

## Test plan
- Load, ready = 1, response one cycle after the handshake, with addr 0x100, mask 4'hF, rdata 0xCAFEBABE. Required: stall for exactly 3 cycles, then `core_rsp_valid` for 1 cycle with rdata 0xCAFEBABE and err 0.
- Store with addr 0x204, mask 4'b0011, wdata 0x1234, ready held low for 2 cycles. Required: bus fields stable through REQ and WAIT, stall for 5 cycles, rsp rdata 0.
- Zero-mask request. Required: no `bus_req_valid`, 1 stall cycle, rsp rdata 0.
- Reset asserted while in WAIT, then a bus response one cycle after release. Required: all outputs 0, state IDLE, response ignored, no `core_rsp_valid`.
- With `DMEM_BRIDGE_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, no response is ever given. Required: DONE after 4 WAIT cycles with err 1 and rdata 0. A late response then produces no pulse.
- Two loads back-to-back, rdata 0x11 then 0x22. Required: two `core_rsp_valid` pulses 4 cycles apart, with correct data in order.
